// File: rtl/cdb_pkg.sv
// Shared CDB definitions: FU finish tags, default field widths and the
// result entry carried from each FU queue to the CDB arbiter.
package cdb_pkg;

  localparam int unsigned CDB_TAG_W  = 4;
  localparam int unsigned CDB_ADDR_W = 5;
  localparam int unsigned CDB_DATA_W = 32;

  typedef enum logic [CDB_TAG_W-1:0] {
    TAG_NONE = 4'd0,
    TAG_ALU1 = 4'd1,
    TAG_ALU2 = 4'd2,
    TAG_ALU3 = 4'd3,
    TAG_MUL1 = 4'd4,
    TAG_MUL2 = 4'd5,
    TAG_DIV1 = 4'd6,
    TAG_MEM1 = 4'd7,
    TAG_MEM2 = 4'd8,
    TAG_JUMP = 4'd9
  } fu_tag_e;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_ADDR_W-1:0] addr;
    logic [CDB_DATA_W-1:0] data;
  } cdb_entry_t;

  // Occupancy view of a result queue, derived from its count.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

endpackage

// File: rtl/cdb_result_queue.sv
// Per-FU result FIFO between writeback and the CDB arbiter; head is popped
// only on grant so results losing arbitration are held, and full stalls the FU.
module cdb_result_queue
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = CDB_TAG_W,
  parameter int unsigned ADDR_W = CDB_ADDR_W,
  parameter int unsigned DATA_W = CDB_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [TAG_W-1:0]         fu_finish,
  input  logic [ADDR_W-1:0]        fu_wt_addr,
  input  logic [DATA_W-1:0]        fu_wt_data,
  input  logic                     cdb_grant,
  output logic [TAG_W-1:0]         head_finish,
  output logic [ADDR_W-1:0]        head_wt_addr,
  output logic [DATA_W-1:0]        head_wt_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cdb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              push_req;
  logic              pop;
  logic              at_cap;
  logic              wr_en;
  logic              drop;
  logic [CNT_W-1:0]  count_next;
  occ_e              occ_next;
  logic              full_next;

  always_comb begin
    push_req   = fu_finish != '0;
    pop        = cdb_grant && (count != '0);
    at_cap     = count == CNT_W'(DEPTH);
    // At capacity a push is only accepted when the same edge frees the head slot.
    wr_en      = push_req && (!at_cap || pop);
    drop       = push_req && at_cap && !pop;
    count_next = count;
    if (wr_en && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !wr_en) begin
      count_next = count - CNT_W'(1);
    end
    if (count_next == '0) begin
      occ_next = OCC_EMPTY;
    end else if (count_next == CNT_W'(DEPTH)) begin
      occ_next = OCC_FULL;
    end else begin
      occ_next = OCC_PARTIAL;
    end
    full_next = occ_next == OCC_FULL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
      full  <= full_next;
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage is deliberately unreset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_en) begin
      mem[wr_ptr] <= '{tag: fu_finish, addr: fu_wt_addr, data: fu_wt_data};
    end
  end

  always_comb begin
    head_finish  = '0;
    head_wt_addr = '0;
    head_wt_data = '0;
    if (count != '0) begin
      head_finish  = mem[rd_ptr].tag;
      head_wt_addr = mem[rd_ptr].addr;
      head_wt_data = mem[rd_ptr].data;
    end
  end

endmodule

// File: tb/tb_cdb_result_queue.sv
// Scoreboard bench for cdb_result_queue: accepted pushes are queued as expected
// heads, and a monitor compares the head on every granted cycle.
module tb_cdb_result_queue;
  import cdb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  fu_finish = '0;
  logic [4:0]  fu_wt_addr = '0;
  logic [31:0] fu_wt_data = '0;
  logic        cdb_grant = 1'b0;
  logic [3:0]  head_finish;
  logic [4:0]  head_wt_addr;
  logic [31:0] head_wt_data;
  logic        full;
  logic [2:0]  count;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;
  cdb_entry_t sb [$];

  cdb_result_queue #(.DEPTH(4), .TAG_W(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_finish(fu_finish), .fu_wt_addr(fu_wt_addr), .fu_wt_data(fu_wt_data),
    .cdb_grant(cdb_grant),
    .head_finish(head_finish), .head_wt_addr(head_wt_addr), .head_wt_data(head_wt_data),
    .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle; 'accepted' says whether this push should enter the queue.
  task automatic drive(input logic [3:0] tag, input logic [4:0] addr, input logic [31:0] data,
                       input logic grant, input logic accepted);
    fu_finish  = tag;
    fu_wt_addr = addr;
    fu_wt_data = data;
    cdb_grant  = grant;
    if (accepted && tag != 4'd0) sb.push_back('{tag: tag, addr: addr, data: data});
    tick();
    fu_finish  = '0;
    fu_wt_addr = '0;
    fu_wt_data = '0;
    cdb_grant  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && !flush && cdb_grant) begin
      if (sb.size() != 0) begin
        cdb_entry_t e;
        e = sb.pop_front();
        check("head_finish", 32'(head_finish), 32'(e.tag));
        check("head_wt_addr", 32'(head_wt_addr), 32'(e.addr));
        check("head_wt_data", head_wt_data, e.data);
      end else begin
        check("empty_head_finish", 32'(head_finish), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_head_finish", 32'(head_finish), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    for (int unsigned i = 0; i < 3; i++) drive(4'd0, 5'd0, 32'd0, 1'b1, 1'b0);
    check("empty_grant_count", 32'(count), 32'd0);

    drive(TAG_ALU1, 5'd5, 32'hA, 1'b0, 1'b1);
    drive(TAG_ALU2, 5'd6, 32'hB, 1'b0, 1'b1);
    drive(TAG_ALU3, 5'd7, 32'hC, 1'b0, 1'b1);
    check("order_count3", 32'(count), 32'd3);
    check("order_head_tag", 32'(head_finish), 32'd1);
    for (int unsigned i = 0; i < 4; i++) drive(4'd0, 5'd0, 32'd0, 1'b1, 1'b0);
    check("order_drained", 32'(count), 32'd0);

    drive(TAG_MUL1, 5'd10, 32'h100, 1'b0, 1'b1);
    drive(TAG_MUL2, 5'd11, 32'h200, 1'b0, 1'b1);
    drive(TAG_DIV1, 5'd12, 32'h300, 1'b0, 1'b1);
    check("partial_full", 32'(full), 32'd0);
    drive(TAG_MEM1, 5'd13, 32'h400, 1'b0, 1'b1);
    check("full_count", 32'(count), 32'd4);
    check("full_flag", 32'(full), 32'd1);
    check("full_no_overflow", 32'(overflow), 32'd0);
    drive(TAG_MEM2, 5'd14, 32'h500, 1'b0, 1'b0);
    check("drop_count", 32'(count), 32'd4);
    check("drop_overflow", 32'(overflow), 32'd1);
    check("drop_head_tag", 32'(head_finish), 32'd4);
    check("drop_head_addr", 32'(head_wt_addr), 32'd10);
    check("drop_head_data", head_wt_data, 32'h100);

    drive(TAG_JUMP, 5'd31, 32'hDEAD_BEEF, 1'b1, 1'b1);
    check("pushpop_full_count", 32'(count), 32'd4);
    check("pushpop_full_flag", 32'(full), 32'd1);
    for (int unsigned i = 0; i < 4; i++) drive(4'd0, 5'd0, 32'd0, 1'b1, 1'b0);
    check("pushpop_drained", 32'(count), 32'd0);
    check("pushpop_full_clear", 32'(full), 32'd0);
    check("pushpop_sb_empty", 32'(sb.size()), 32'd0);

    for (int unsigned i = 0; i < 10; i++) begin
      drive(4'((i % 9) + 1), 5'(i + 16), 32'h1000 + 32'(i), (i != 0), 1'b1);
      check("wrap_count", 32'(count), 32'd1);
    end
    drive(4'd0, 5'd0, 32'd0, 1'b1, 1'b0);
    check("wrap_drained", 32'(count), 32'd0);

    drive(TAG_ALU1, 5'd1, 32'h11, 1'b0, 1'b1);
    drive(TAG_ALU2, 5'd2, 32'h22, 1'b0, 1'b1);
    drive(TAG_ALU3, 5'd3, 32'h33, 1'b0, 1'b1);
    check("preflush_count", 32'(count), 32'd3);
    flush = 1'b1;
    sb.delete();
    drive(TAG_MUL1, 5'd4, 32'h44, 1'b0, 1'b0);
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_head", 32'(head_finish), 32'd0);
    check("flush_full", 32'(full), 32'd0);
    check("flush_keeps_overflow", 32'(overflow), 32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_clears_overflow", 32'(overflow), 32'd0);
    check("rst_count2", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
